deskew: RTL and testbench
=========================

# deskew

Re-aligns a skewed multi-lane bus so that all lanes of one word leave on the same cycle. Upstream staggered delay stages feed systolic rows so that lane i lags lane 0 by i cycles. This block sits at the array output and undoes that skew: lane i is delayed by size-1-i cycles, then all lanes pass through a common output register. It also tracks per-lane valid bits, counts aligned words, and flags lanes that arrive inconsistently.

## Interface
Parameters:
- data_size, 16, width of one lane in bits
- size, 4, number of lanes (≥1); lane i occupies bits [data_size*(i+1)-1 : data_size*i]
- count_width, 16, width of the aligned-word counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- bus_in  input  data_size*size  skewed data; lane i carries word n i cycles after lane 0 did
- valid_in  input  size  per-lane valid, skewed identically to bus_in
- bus_out  output  data_size*size  aligned data, registered
- valid_out  output  1  high when every lane of the aligned word was valid
- count_out  output  count_width  number of aligned words emitted since reset, saturating
- error  output  1  sticky; a word had some lanes valid and others not

## Operation
- Lane i: data and valid pass through a shift register of depth size-1-i, then into the common output register. Lane size-1 has depth 0 and goes straight into the output register.
- bus_out loads the aligned data every cycle, whatever the valid bits. valid_out qualifies it.
- valid_out ← AND of the aligned valid bits.
- count_out increments when valid_out is loaded as 1. It saturates at 2^count_width-1.
- Partial word means the aligned valid bits are neither all 0 nor all 1. A partial word sets error, which holds until reset. The partial word is dropped: valid_out=0 and no count.
- Guard counter: for size-1 cycles after reset deasserts, partial words do not set error. These are words straddling the reset. They are still dropped.
- Reset: all shift stages, bus_out, valid_out, count_out and error go to 0, and the guard counter loads size-1. In-flight words are discarded.

## Timing
- Lane 0 sampled at edge t appears in bus_out after edge t+size-1. Lane i sampled at edge t+i appears after the same edge.
- Latency from lane 0 is size cycles of registers: size-1 buffer stages plus the output register. Lane size-1 has latency 1.
- Throughput is one word per cycle, with no stalls and no backpressure.
- Reset asserted at edge r: all outputs are 0 after edge r.
  - The first lane-0 data sampled at edge r+1 appears at edge r+size.
  - Guard is active for edges r+1 … r+size-1.
- size=1: no buffer stages, 1-cycle latency, guard length 0.
- count_out saturation: stays at max when a further valid word arrives. error is not affected.
- Simultaneous reset and valid input: reset wins, and the input is discarded.

## Structure
- Package deskew_pkg holds shared constants. This includes the default count_width and a lane-slice helper function (lane index → bit offset) used by this block and its testbench.
- One natural sub-module, deskew_lane: a single-lane shift register of parameterized depth (0 = passthrough) with synchronous reset, carrying data_size+1 bits (data plus valid). It is instantiated size times with a generate loop, at depth size-1-i.
- The output register, counter, guard counter and error flag live in the top module.

## Test plan
All scenarios use size=4 and data_size=16 unless noted.
- Aligned stream: drive word n with lane i value 16'h0n0i at cycle n+i, all valid.
  - Required: bus_out = {0n03,0n02,0n01,0n00} with valid_out=1, starting at edge 4 and one word per cycle.
  - Required: after 10 words, count_out=10 and error=0.
- Reset values: assert reset for 2 cycles with random inputs. Required: bus_out=0, valid_out=0, count_out=0, error=0 after the first reset edge.
- Partial word: skew a word correctly but drop lane 2's valid.
  - Required: that cycle has valid_out=0, count_out does not increment, error=1 from then on.
  - Required: error stays 1 through subsequent good words.
- Reset mid-stream: reset while 3 words are in flight, then resume a clean skewed stream at once.
  - Required: no error from the straddling fragments.
  - Required: the first new word aligns at edge reset+4, and count_out restarts from 0.
- Saturation: with count_width=3, send 9 valid words. Required: count_out reads 7 after the 7th word and stays 7.
- Degenerate size=1: value 16'hBEEF valid at edge t. Required: bus_out=BEEF and valid_out=1 after edge t, and no guard period.

Source files
------------

// File: rtl/deskew_pkg.sv
// Shared constants and lane-slicing helper for the deskew block and its bench.
package deskew_pkg;

  localparam int unsigned DEFAULT_COUNT_WIDTH = 16;

  // Bit offset of lane `lane` in a bus of `width`-bit lanes.
  function automatic int unsigned lane_offset(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/deskew_lane.sv
// Single-lane delay line of `depth` stages carrying data plus its valid bit.
module deskew_lane #(
  parameter int unsigned data_size = 16,
  parameter int unsigned depth     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [data_size:0] d_in,
  output logic [data_size:0] d_out
);

  if (depth == 0) begin : g_pass
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign d_out = d_in;
  end else begin : g_shift
    logic [data_size:0] stage_q [depth];
    logic [data_size:0] stage_d [depth];

    always_comb begin
      stage_d[0] = d_in;
      for (int unsigned k = 1; k < depth; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < depth; k++) begin
        stage_q[k] <= reset ? '0 : stage_d[k];
      end
    end

    assign d_out = stage_q[depth-1];
  end

endmodule

// File: rtl/deskew.sv
// Undoes a per-lane staircase skew, then registers the aligned word with
// valid qualification, a saturating word counter and a sticky partial-word flag.
module deskew
  import deskew_pkg::*;
#(
  parameter int unsigned data_size   = 16,
  parameter int unsigned size        = 4,
  parameter int unsigned count_width = DEFAULT_COUNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [data_size*size-1:0]   bus_in,
  input  logic [size-1:0]             valid_in,
  output logic [data_size*size-1:0]   bus_out,
  output logic                        valid_out,
  output logic [count_width-1:0]      count_out,
  output logic                        error
);

  localparam int unsigned GUARD_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(size - 1);

  logic [data_size*size-1:0] aligned_data;
  logic [size-1:0]           aligned_valid;

  for (genvar i = 0; i < size; i++) begin : g_lane
    logic [data_size:0] lane_out;

    deskew_lane #(
      .data_size (data_size),
      .depth     (size - 1 - i)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .d_in  ({valid_in[i], bus_in[lane_offset(i, data_size) +: data_size]}),
      .d_out (lane_out)
    );

    assign aligned_valid[i] = lane_out[data_size];
    assign aligned_data[lane_offset(i, data_size) +: data_size] = lane_out[data_size-1:0];
  end

  logic [data_size*size-1:0] bus_out_q, bus_out_d;
  logic                      valid_out_q, valid_out_d;
  logic [count_width-1:0]    count_q, count_d;
  logic                      error_q, error_d;
  logic [GUARD_W-1:0]        guard_q, guard_d;
  logic                      all_valid, partial;

  always_comb begin
    all_valid   = &aligned_valid;
    partial     = (|aligned_valid) & ~all_valid;
    bus_out_d   = aligned_data;
    valid_out_d = all_valid;

    count_d = count_q;
    if (all_valid && count_q != '1) begin
      count_d = count_q + 1'b1;
    end

    // Guard covers fragments of words that straddled reset: they are still
    // dropped (valid_out=0) but must not raise the sticky error.
    guard_d = guard_q;
    if (guard_q != '0) begin
      guard_d = guard_q - 1'b1;
    end

    error_d = error_q | (partial && guard_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_out_q   <= '0;
      valid_out_q <= 1'b0;
      count_q     <= '0;
      error_q     <= 1'b0;
      guard_q     <= GUARD_INIT;
    end else begin
      bus_out_q   <= bus_out_d;
      valid_out_q <= valid_out_d;
      count_q     <= count_d;
      error_q     <= error_d;
      guard_q     <= guard_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign valid_out = valid_out_q;
  assign count_out = count_q;
  assign error     = error_q;

endmodule

// File: tb/tb_deskew.sv
// Directed bench for deskew: two size-4 instances (16-bit and 3-bit counters)
// share a skewed stimulus; a size-1 instance checks the degenerate case.
module tb_deskew;
  import deskew_pkg::*;

  logic        clk;
  logic        rst;
  logic [63:0] bus_a;
  logic [3:0]  vin_a;
  logic [63:0] bus_out_a, bus_out_b;
  logic        vout_a, vout_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;
  logic        err_a, err_b;
  logic [15:0] bus_c, bus_out_c;
  logic [0:0]  vin_c;
  logic        vout_c, err_c;
  logic [15:0] cnt_c;

  deskew #(.data_size(16), .size(4), .count_width(16)) u_dut_a (
    .clk(clk), .reset(rst), .bus_in(bus_a), .valid_in(vin_a),
    .bus_out(bus_out_a), .valid_out(vout_a), .count_out(cnt_a), .error(err_a));

  deskew #(.data_size(16), .size(4), .count_width(3)) u_dut_b (
    .clk(clk), .reset(rst), .bus_in(bus_a), .valid_in(vin_a),
    .bus_out(bus_out_b), .valid_out(vout_b), .count_out(cnt_b), .error(err_b));

  deskew #(.data_size(16), .size(1), .count_width(16)) u_dut_c (
    .clk(clk), .reset(rst), .bus_in(bus_c), .valid_in(vin_c),
    .bus_out(bus_out_c), .valid_out(vout_c), .count_out(cnt_c), .error(err_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_cnt, exp_cnt_b;
  logic exp_err;
  int s_nwords, s_drop_w, s_drop_l, s_old_off, s_old_end;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_val(input int n, input int i);
    return 16'(((n & 15) << 8) | (i & 15));
  endfunction

  // Lane i at stream cycle c carries new word c-i; otherwise the tail of an
  // older stream interrupted by reset (old word c+s_old_off-i).
  task automatic drive_a(input int c);
    for (int i = 0; i < 4; i++) begin
      int n, no;
      n  = c - i;
      no = c + s_old_off - i;
      if (n >= 0 && n < s_nwords) begin
        bus_a[lane_offset(i, 16) +: 16] = word_val(n, i);
        vin_a[i] = !(n == s_drop_w && i == s_drop_l);
      end else if (s_old_end >= 0 && no >= 0 && no <= s_old_end) begin
        bus_a[lane_offset(i, 16) +: 16] = word_val(no, i);
        vin_a[i] = 1'b1;
      end else begin
        bus_a[lane_offset(i, 16) +: 16] = 16'h0;
        vin_a[i] = 1'b0;
      end
    end
  endtask

  task automatic check_cycle(input int c);
    int n;
    logic exp_v;
    logic [63:0] exp_bus;
    n = c - 3;
    exp_v = 1'b0;
    if (n >= 0 && n < s_nwords) begin
      for (int i = 0; i < 4; i++) exp_bus[lane_offset(i, 16) +: 16] = word_val(n, i);
      chk("bus_out", bus_out_a, exp_bus);
      if (n == s_drop_w) begin
        exp_err = 1'b1;
      end else begin
        exp_v = 1'b1;
        exp_cnt++;
        if (exp_cnt_b < 7) exp_cnt_b++;
      end
    end
    chk("valid_out", 64'(vout_a), 64'(exp_v));
    chk("count_out", 64'(cnt_a), 64'(exp_cnt));
    chk("error", 64'(err_a), 64'(exp_err));
    chk("sat_count", 64'(cnt_b), 64'(exp_cnt_b));
    chk("sat_error", 64'(err_b), 64'(exp_err));
  endtask

  task automatic run_stream(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      drive_a(c);
      @(posedge clk); #1;
      check_cycle(c);
    end
  endtask

  task automatic check_reset_a();
    chk("rst_bus", bus_out_a, 64'h0);
    chk("rst_valid", 64'(vout_a), 64'h0);
    chk("rst_count", 64'(cnt_a), 64'h0);
    chk("rst_error", 64'(err_a), 64'h0);
    chk("rst_count_b", 64'(cnt_b), 64'h0);
  endtask

  initial begin
    bus_c = 16'h0; vin_c = 1'b0;
    s_nwords = 0; s_drop_w = -1; s_drop_l = -1; s_old_off = 0; s_old_end = -1;

    // Reset with random inputs for two cycles.
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus_a = {$urandom, $urandom};
      vin_a = 4'($urandom);
      @(posedge clk); #1;
      check_reset_a();
    end
    exp_cnt = 0; exp_cnt_b = 0; exp_err = 1'b0;
    rst = 1'b0;

    // Aligned stream of 10 words; B saturates at 7.
    s_nwords = 10;
    run_stream(14);
    chk("count_after_10", 64'(cnt_a), 64'd10);
    chk("sat_hold_7", 64'(cnt_b), 64'd7);

    // Partial word: word 1 lane 2 invalid.
    s_nwords = 4; s_drop_w = 1; s_drop_l = 2;
    run_stream(8);
    chk("count_after_partial", 64'(cnt_a), 64'd13);
    s_drop_w = -1; s_drop_l = -1; s_nwords = 3;
    run_stream(7);
    chk("error_sticky", 64'(err_a), 64'h1);

    // Reset mid-stream: old stream reaches cycle 5, reset at cycle 6.
    s_nwords = 10;
    run_stream(6);
    drive_a(6);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_a();
    rst = 1'b0;
    exp_cnt = 0; exp_cnt_b = 0; exp_err = 1'b0;
    s_nwords = 5; s_old_off = 7; s_old_end = 6;
    run_stream(9);
    chk("count_restart", 64'(cnt_a), 64'd5);
    chk("no_straddle_error", 64'(err_a), 64'h0);
    s_old_end = -1; s_nwords = 0;

    // Degenerate size=1 instance.
    drive_a(0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("c_rst_bus", 64'(bus_out_c), 64'h0);
    chk("c_rst_count", 64'(cnt_c), 64'h0);
    rst = 1'b0;
    bus_c = 16'hBEEF; vin_c = 1'b1;
    @(posedge clk); #1;
    chk("c_bus", 64'(bus_out_c), 64'hBEEF);
    chk("c_valid", 64'(vout_c), 64'h1);
    chk("c_count", 64'(cnt_c), 64'h1);
    bus_c = 16'h1234; vin_c = 1'b0;
    @(posedge clk); #1;
    chk("c_bus_invalid", 64'(bus_out_c), 64'h1234);
    chk("c_valid_low", 64'(vout_c), 64'h0);
    chk("c_count_hold", 64'(cnt_c), 64'h1);
    chk("c_error", 64'(err_c), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
